// File: rtl/mm_trg_pkg.sv
// Shared definitions for the multi-channel minimum trigger.
//   EXEC_INIT / EXEC_TRG : run-control encodings on EXEC_STATE (others = HOLD)
//   ch_state_t           : per-channel frame state
//   clogb2(v)            : number of bits needed to hold the value v
package mm_trg_pkg;

  localparam logic [1:0] EXEC_INIT = 2'b00;
  localparam logic [1:0] EXEC_TRG  = 2'b11;

  // Each packed sample occupies a 16-bit slot of TDATA.
  localparam int SLOT_W = 16;

  typedef enum logic [2:0] {
    ST_CALB   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_POST   = 3'd3,
    ST_FINAL  = 3'd4
  } ch_state_t;

  // Bits needed to represent 'value' itself (counters must reach the limit).
  function automatic int clogb2(input int value);
    int bits;
    bits = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/mm_trg_ch.sv
// One channel of the minimum trigger: baseline-subtracted threshold compare
// over every packed sample, frame FSM, length and tail counters.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_exec_state        run control (INIT / TRG / HOLD)
//   i_current_time      free-running time, latched when a frame opens
//   i_tdata, i_tvalid   this channel's AXIS beat
//   i_baseline          signed baseline
//   i_threshold         unsigned threshold magnitude
//   i_hysteresis        unsigned hysteresis below threshold
//   i_polarity          0 positive pulses, 1 negative pulses
//   o_triggered_flag    high while a frame is open
//   o_time_stamp        time of the frame's opening beat
//   o_finalize          1-cycle pulse when a frame closes
//   o_over_len          1-cycle pulse when a frame is truncated
//   o_dbg_state         current FSM state
//
// Handshake: a beat is any cycle with i_tvalid=1; there is no back-pressure,
// and cycles without a beat leave state, counters and the time stamp untouched.
module mm_trg_ch
  import mm_trg_pkg::*;
#(
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128,
  parameter int TIME_STAMP_WIDTH     = 16,
  parameter int POST_ACQUI_LEN       = 38,
  parameter int ACQUI_LEN            = 100
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [1:0]                      i_exec_state,
  input  logic [TIME_STAMP_WIDTH-1:0]     i_current_time,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   i_tdata,
  input  logic                            i_tvalid,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] i_baseline,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] i_threshold,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] i_hysteresis,
  input  logic                            i_polarity,
  output logic                            o_triggered_flag,
  output logic [TIME_STAMP_WIDTH-1:0]     o_time_stamp,
  output logic                            o_finalize,
  output logic                            o_over_len,
  output logic [2:0]                      o_dbg_state
);

  localparam int ADC    = ADC_RESOLUTION_WIDTH;
  localparam int SPT    = S_AXIS_TDATA_WIDTH / SLOT_W;
  localparam int LEN_W  = clogb2(ACQUI_LEN);
  localparam int POST_W = clogb2(POST_ACQUI_LEN);

  // ---------------- compare tree ----------------
  logic [ADC-1:0]        w_lo;
  logic signed [ADC+1:0] w_thr_s;
  logic signed [ADC+1:0] w_lo_s;
  logic [SPT-1:0]        w_hit_vec;
  logic [SPT-1:0]        w_hold_vec;
  logic                  w_hit;
  logic                  w_hold;

  // Lower (hold) level saturates at zero when hysteresis exceeds threshold.
  assign w_lo    = (i_threshold >= i_hysteresis) ? (i_threshold - i_hysteresis) : '0;
  assign w_thr_s = $signed({2'b00, i_threshold});
  assign w_lo_s  = $signed({2'b00, w_lo});

  for (genvar gi = 0; gi < SPT; gi++) begin : g_smp
    logic [ADC-1:0]           w_smp;
    logic [SLOT_W-ADC-1:0]    w_unused_pad;
    logic signed [ADC:0]      w_d;
    logic signed [ADC+1:0]    w_dx;
    assign w_smp        = i_tdata[gi*SLOT_W +: ADC];
    assign w_unused_pad = i_tdata[gi*SLOT_W+ADC +: SLOT_W-ADC];
    assign w_d  = $signed({w_smp[ADC-1], w_smp}) - $signed({i_baseline[ADC-1], i_baseline});
    // One extra bit so negating the most negative difference cannot overflow.
    assign w_dx = i_polarity ? -{w_d[ADC], w_d} : {w_d[ADC], w_d};
    assign w_hit_vec[gi]  = (w_dx >= w_thr_s);
    assign w_hold_vec[gi] = (w_dx >= w_lo_s);
  end

  assign w_hit  = |w_hit_vec;
  assign w_hold = |w_hold_vec;

  // ---------------- FSM and counters ----------------
  ch_state_t                   r_state, w_state_nxt;
  logic [LEN_W-1:0]            r_len, w_len_nxt, w_len_inc;
  logic [POST_W-1:0]           r_post, w_post_nxt, w_post_inc;
  logic [TIME_STAMP_WIDTH-1:0] r_ts, w_ts_nxt;
  logic                        r_flag, w_flag_nxt;
  logic                        r_fin, w_fin_nxt;
  logic                        r_ovl, w_ovl_nxt;
  logic                        w_len_full;
  logic                        w_post_done;

  // Limits are checked on the incremented values: the beat that brings the
  // count to the limit is the last beat of the frame / tail.
  assign w_len_inc   = r_len + 1'b1;
  assign w_post_inc  = r_post + 1'b1;
  assign w_len_full  = (w_len_inc == LEN_W'(ACQUI_LEN));
  assign w_post_done = (w_post_inc == POST_W'(POST_ACQUI_LEN));

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_post_nxt  = r_post;
    w_ts_nxt    = r_ts;
    w_flag_nxt  = r_flag;
    w_fin_nxt   = 1'b0;
    w_ovl_nxt   = 1'b0;
    if (i_exec_state == EXEC_INIT) begin
      // Abort any open frame silently.
      w_state_nxt = ST_CALB;
      w_len_nxt   = '0;
      w_post_nxt  = '0;
      w_ts_nxt    = '0;
      w_flag_nxt  = 1'b0;
    end else if (i_exec_state == EXEC_TRG && i_tvalid) begin
      case (r_state)
        ST_CALB: w_state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (w_hit) begin
            w_state_nxt = ST_ACTIVE;
            w_flag_nxt  = 1'b1;
            w_ts_nxt    = i_current_time;
            w_len_nxt   = LEN_W'(1);
            w_post_nxt  = '0;
          end
        end
        ST_ACTIVE: begin
          w_len_nxt = w_len_inc;
          if (w_len_full) begin
            w_state_nxt = ST_FINAL;
            w_flag_nxt  = 1'b0;
            w_fin_nxt   = 1'b1;
            w_ovl_nxt   = 1'b1;
          end else if (!w_hold) begin
            w_state_nxt = ST_POST;
            w_post_nxt  = POST_W'(1);
          end
        end
        ST_POST: begin
          w_len_nxt  = w_len_inc;
          w_post_nxt = w_post_inc;
          if (w_len_full) begin
            w_state_nxt = ST_FINAL;
            w_flag_nxt  = 1'b0;
            w_fin_nxt   = 1'b1;
            w_ovl_nxt   = 1'b1;
          end else if (w_hit) begin
            w_state_nxt = ST_ACTIVE;
            w_post_nxt  = '0;
          end else if (w_post_done) begin
            w_state_nxt = ST_FINAL;
            w_flag_nxt  = 1'b0;
            w_fin_nxt   = 1'b1;
          end
        end
        // Dead beat after a close: any hit here is ignored.
        ST_FINAL: w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_CALB;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_CALB;
      r_len   <= '0;
      r_post  <= '0;
      r_ts    <= '0;
      r_flag  <= 1'b0;
      r_fin   <= 1'b0;
      r_ovl   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_post  <= w_post_nxt;
      r_ts    <= w_ts_nxt;
      r_flag  <= w_flag_nxt;
      r_fin   <= w_fin_nxt;
      r_ovl   <= w_ovl_nxt;
    end
  end

  assign o_triggered_flag = r_flag;
  assign o_time_stamp     = r_ts;
  assign o_finalize       = r_fin;
  assign o_over_len       = r_ovl;
  assign o_dbg_state      = r_state;

endmodule

// File: rtl/mm_trg_multi.sv
// Multi-channel minimum trigger between the RF Data Converter AXIS streams
// and the frame builder. One independent mm_trg_ch per ADC channel.
// Ports (channel c occupies slice c of each per-channel bus):
//   AXIS_ACLK, AXIS_ARESET  clock, synchronous active-high reset
//   EXEC_STATE              00 INIT, 11 TRG, others HOLD
//   CURRENT_TIME            free-running time
//   S_AXIS_TDATA/TVALID     per-channel sample beats
//   BASELINE, THRESHOLD     per-channel signed baseline / unsigned threshold
//   HYSTERESIS              shared hysteresis
//   POLARITY                per-channel pulse polarity
//   O_TRIGGERED_FLAG, O_TIME_STAMP, O_FINALIZE, O_OVER_LEN  per-channel results
//   O_DBG_STATE             per-channel FSM state, 3 bits each
module mm_trg_multi
  import mm_trg_pkg::*;
#(
  parameter int N_CH                 = 2,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128,
  parameter int TIME_STAMP_WIDTH     = 16,
  parameter int POST_ACQUI_LEN       = 38,
  parameter int ACQUI_LEN            = 100
) (
  input  logic                                 AXIS_ACLK,
  input  logic                                 AXIS_ARESET,
  input  logic [1:0]                           EXEC_STATE,
  input  logic [TIME_STAMP_WIDTH-1:0]          CURRENT_TIME,
  input  logic [N_CH*S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [N_CH-1:0]                      S_AXIS_TVALID,
  input  logic [N_CH*ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  input  logic [N_CH*ADC_RESOLUTION_WIDTH-1:0] THRESHOLD,
  input  logic [ADC_RESOLUTION_WIDTH-1:0]      HYSTERESIS,
  input  logic [N_CH-1:0]                      POLARITY,
  output logic [N_CH-1:0]                      O_TRIGGERED_FLAG,
  output logic [N_CH*TIME_STAMP_WIDTH-1:0]     O_TIME_STAMP,
  output logic [N_CH-1:0]                      O_FINALIZE,
  output logic [N_CH-1:0]                      O_OVER_LEN,
  output logic [N_CH*3-1:0]                    O_DBG_STATE
);

  localparam int ADC = ADC_RESOLUTION_WIDTH;
  localparam int W   = S_AXIS_TDATA_WIDTH;
  localparam int TSW = TIME_STAMP_WIDTH;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mm_trg_ch #(
      .ADC_RESOLUTION_WIDTH (ADC),
      .S_AXIS_TDATA_WIDTH   (W),
      .TIME_STAMP_WIDTH     (TSW),
      .POST_ACQUI_LEN       (POST_ACQUI_LEN),
      .ACQUI_LEN            (ACQUI_LEN)
    ) u_ch (
      .i_clk            (AXIS_ACLK),
      .i_rst            (AXIS_ARESET),
      .i_exec_state     (EXEC_STATE),
      .i_current_time   (CURRENT_TIME),
      .i_tdata          (S_AXIS_TDATA[c*W +: W]),
      .i_tvalid         (S_AXIS_TVALID[c]),
      .i_baseline       (BASELINE[c*ADC +: ADC]),
      .i_threshold      (THRESHOLD[c*ADC +: ADC]),
      .i_hysteresis     (HYSTERESIS),
      .i_polarity       (POLARITY[c]),
      .o_triggered_flag (O_TRIGGERED_FLAG[c]),
      .o_time_stamp     (O_TIME_STAMP[c*TSW +: TSW]),
      .o_finalize       (O_FINALIZE[c]),
      .o_over_len       (O_OVER_LEN[c]),
      .o_dbg_state      (O_DBG_STATE[c*3 +: 3])
    );
  end

endmodule
